// File: rtl/fft_bitrev_reorder_if.sv
// Stream bundle around the bit-reverse reorder buffer: bit-reversed input
// samples from the SDF FFT pipeline, natural-order output samples, and the
// sticky framing error flag.
interface fft_bitrev_reorder_if #(
    parameter int LOG2N  = 10,
    parameter int DATA_W = 16
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_re;
    logic signed [DATA_W-1:0] in_im;
    logic                     in_last;

    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_re;
    logic signed [DATA_W-1:0] out_im;
    logic [LOG2N-1:0]         out_idx;
    logic                     out_last;

    logic                     err_sync;

    // Producer of input samples and consumer of output samples.
    modport master (
        output in_valid, in_re, in_im, in_last, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_idx, out_last, err_sync
    );

    // The reorder buffer itself.
    modport slave (
        input  in_valid, in_re, in_im, in_last, out_ready,
        output in_ready, out_valid, out_re, out_im, out_idx, out_last, err_sync
    );
endinterface

// File: rtl/fft_bitrev_reorder.sv
// Bit-reverse to natural-order reorder buffer for the SDF FFT output.
// Frames of FFT_N complex samples are written into one bank of a ping-pong
// RAM at the bit-reversed address and replayed from the other bank in
// natural order over a valid/ready stream.
//
// Read FSM
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   S_IDLE   | output registers empty, waiting for bank_full[rd_bank]
//   S_STREAM | output registers hold a sample of bank rd_bank
module fft_bitrev_reorder #(
    parameter int FFT_N  = 1024,
    parameter int LOG2N  = 10,
    parameter int DATA_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    fft_bitrev_reorder_if.slave  bus
);
    localparam int               WORD_W   = 2 * DATA_W;
    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(FFT_N - 1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } rd_state_t;

    // Bank select is the address MSB.
    logic [WORD_W-1:0] mem [2*FFT_N];

    logic [LOG2N-1:0]         wr_cnt_q;
    logic                     wr_bank_q;
    logic [1:0]               bank_full_q;
    logic [1:0]               bank_full_d;
    logic                     err_sync_q;

    rd_state_t                state_q;
    logic                     rd_bank_q;
    logic [LOG2N-1:0]         rd_cnt_q;
    logic                     out_valid_q;
    logic signed [DATA_W-1:0] out_re_q;
    logic signed [DATA_W-1:0] out_im_q;
    logic [LOG2N-1:0]         out_idx_q;
    logic                     out_last_q;

    logic                     in_ready;
    logic                     wr_fire;
    logic                     wr_at_last;
    logic                     wr_wrap;
    logic                     out_fire;
    logic                     rd_release;
    logic                     fetch_bank;
    logic                     fetch;
    logic [WORD_W-1:0]        rd_word;

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) begin
            r[i] = a[LOG2N-1-i];
        end
        return r;
    endfunction

    // Handshake and fetch qualifiers.
    always_comb begin
        in_ready   = ~bank_full_q[wr_bank_q];
        wr_fire    = bus.in_valid & in_ready;
        wr_at_last = (wr_cnt_q == LAST_IDX);
        wr_wrap    = wr_fire & wr_at_last;
        out_fire   = out_valid_q & bus.out_ready;
        rd_release = out_fire & out_last_q;
        // Once the last word of a bank is leaving, the next fetch comes from
        // index 0 of the other bank (rd_cnt has already wrapped to 0).
        fetch_bank = rd_release ? ~rd_bank_q : rd_bank_q;
        // The output registers double as the RAM read register; qualifying the
        // fetch with out_ready in the same cycle sustains one sample per clock
        // without a separate skid entry and freezes everything on a stall.
        fetch      = bank_full_q[fetch_bank] & (~out_valid_q | bus.out_ready);
        rd_word    = mem[{fetch_bank, rd_cnt_q}];
    end

    // Frame RAM write port: sample k of a frame lands at bitrev(k).
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[{wr_bank_q, bitrev(wr_cnt_q)}] <= {bus.in_re, bus.in_im};
        end
    end

    // Write-side counters and the sticky framing check; framing is by count only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_q   <= '0;
            wr_bank_q  <= 1'b0;
            err_sync_q <= 1'b0;
        end else begin
            if (wr_fire) begin
                wr_cnt_q <= wr_cnt_q + LOG2N'(1);
                if (bus.in_last != wr_at_last) begin
                    err_sync_q <= 1'b1;
                end
            end
            if (wr_wrap) begin
                wr_bank_q <= ~wr_bank_q;
            end
        end
    end

    // Bank ownership: set by the writer on frame completion, cleared by the
    // reader on the out_last handshake; the two always target different banks.
    always_comb begin
        bank_full_d = bank_full_q;
        if (wr_wrap) begin
            bank_full_d[wr_bank_q] = 1'b1;
        end
        if (rd_release) begin
            bank_full_d[rd_bank_q] = 1'b0;
        end
    end

    // Bank occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_full_q <= 2'b00;
        end else begin
            bank_full_q <= bank_full_d;
        end
    end

    // Read FSM with registered output sample, index and last flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            rd_bank_q   <= 1'b0;
            rd_cnt_q    <= '0;
            out_valid_q <= 1'b0;
            out_re_q    <= '0;
            out_im_q    <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            if (fetch) begin
                out_re_q   <= rd_word[WORD_W-1:DATA_W];
                out_im_q   <= rd_word[DATA_W-1:0];
                out_idx_q  <= rd_cnt_q;
                out_last_q <= (rd_cnt_q == LAST_IDX);
                rd_cnt_q   <= rd_cnt_q + LOG2N'(1);
            end
            case (state_q)
                S_IDLE: begin
                    if (fetch) begin
                        state_q     <= S_STREAM;
                        out_valid_q <= 1'b1;
                    end
                end
                S_STREAM: begin
                    if (rd_release) begin
                        rd_bank_q <= ~rd_bank_q;
                        if (!fetch) begin
                            state_q     <= S_IDLE;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_re    = out_re_q;
    assign bus.out_im    = out_im_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
    assign bus.err_sync  = err_sync_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for the bit-reverse reorder buffer (FFT_N = 8). A frame-level model
// (arrival buffer, natural-order expectation queue, sample/frame counts)
// is checked against the DUT on every falling edge.
module tb_fft_bitrev_reorder;
    localparam int N  = 8;
    localparam int LG = 3;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fft_bitrev_reorder_if #(.LOG2N(LG), .DATA_W(DW)) bus ();

    fft_bitrev_reorder #(.FFT_N(N), .LOG2N(LG), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    function automatic int brev(input int k);
        int r = 0;
        for (int b = 0; b < LG; b++) begin
            if ((k >> b) & 1) r = r | (1 << (LG - 1 - b));
        end
        return r;
    endfunction

    typedef struct {
        int re;
        int im;
        int idx;
    } samp_t;

    samp_t exp_q[$];
    int    fr_re[N];
    int    fr_im[N];
    int    wr_k, frames_in, frames_out, delivered, avail, last_wr_cyc;
    bit    err_exp, want_valid, hold, hs;
    int    p_re, p_im, p_idx, p_last;
    samp_t e;
    int    log_re[$], log_im[$], log_idx[$], log_cyc[$];
    bit    rand_rdy = 1'b0;
    int    t2_re[N] = '{0, 4, 2, 6, 1, 5, 3, 7};

    // Compare process: DUT outputs against the frame model every cycle.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            wr_k = 0; frames_in = 0; frames_out = 0; delivered = 0;
            err_exp = 0; want_valid = 0; hold = 0;
        end else begin
            chk("out_valid", bus.out_valid, want_valid);
            chk("in_ready", bus.in_ready, (frames_in - frames_out) < 2);
            chk("err_sync", bus.err_sync, err_exp);
            if (hold) begin
                chk("hold_re", $signed(bus.out_re), p_re);
                chk("hold_im", $signed(bus.out_im), p_im);
                chk("hold_idx", bus.out_idx, p_idx);
                chk("hold_last", bus.out_last, p_last);
            end
            hs = bus.out_valid && bus.out_ready;
            if (hs) begin
                chk("out_has_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("out_re", $signed(bus.out_re), e.re);
                    chk("out_im", $signed(bus.out_im), e.im);
                    chk("out_idx", bus.out_idx, e.idx);
                    chk("out_last", bus.out_last, e.idx == N - 1);
                end
                log_re.push_back($signed(bus.out_re));
                log_im.push_back($signed(bus.out_im));
                log_idx.push_back(bus.out_idx);
                log_cyc.push_back(cyc);
            end
            // A sample is presented next cycle iff a completed frame still holds
            // an undelivered sample after this cycle's handshake.
            avail = frames_in * N - delivered;
            want_valid = (avail - (hs ? 1 : 0)) > 0;
            if (hs) begin
                delivered++;
                if (delivered % N == 0) frames_out++;
            end
            if (bus.in_valid && bus.in_ready) begin
                fr_re[wr_k] = $signed(bus.in_re);
                fr_im[wr_k] = $signed(bus.in_im);
                if (bus.in_last != (wr_k == N - 1)) err_exp = 1;
                if (wr_k == N - 1) begin
                    for (int i = 0; i < N; i++) begin
                        exp_q.push_back('{fr_re[brev(i)], fr_im[brev(i)], i});
                    end
                    frames_in++;
                    last_wr_cyc = cyc;
                end
                wr_k = (wr_k + 1) % N;
            end
            hold   = bus.out_valid && !bus.out_ready;
            p_re   = $signed(bus.out_re);
            p_im   = $signed(bus.out_im);
            p_idx  = bus.out_idx;
            p_last = bus.out_last;
        end
    end

    // Random downstream back-pressure when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) bus.out_ready = ($urandom_range(0, 1) == 1);
        end
    end

    task automatic clear_log();
        log_re.delete(); log_im.delete(); log_idx.delete(); log_cyc.delete();
    endtask

    task automatic send(input int re, input int im, input bit last);
        int  n   = 0;
        bit  acc = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_re    = DW'(re);
        bus.in_im    = DW'(im);
        bus.in_last  = last;
        while (!acc && n < 300) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) chk("send_timeout", acc, 1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_in_budget", n < budget, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_re     = '0;
        bus.in_im     = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Power-on reset
        idle(3);
        #2;
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_idx", bus.out_idx, 0);
        chk("rst_err_sync", bus.err_sync, 0);
        rst = 1'b0;
        idle(1);
        chk("rst_in_ready", bus.in_ready, 1);

        // One frame, natural-order replay and latency
        clear_log();
        bus.out_ready = 1'b1;
        for (int k = 0; k < N; k++) send(k, -k, k == N - 1);
        wait_drain(200);
        chk("t2_count", log_re.size(), N);
        if (log_re.size() == N) begin
            for (int i = 0; i < N; i++) begin
                chk("t2_re", log_re[i], t2_re[i]);
                chk("t2_im", log_im[i], -t2_re[i]);
                chk("t2_idx", log_idx[i], i);
            end
            chk("t2_latency", log_cyc[0] - last_wr_cyc, 2);
        end
        idle(2);

        // Three back-to-back frames
        clear_log();
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < N; k++) send(f * N + k + 1, -(f * N + k + 1), k == N - 1);
        end
        wait_drain(300);
        chk("t3_count", log_re.size(), 3 * N);
        if (log_cyc.size() == 3 * N) begin
            chk("t3_f1_f2_no_bubble", log_cyc[N] - log_cyc[N - 1], 1);
            for (int i = 1; i < 3 * N; i++) begin
                if (i % N != 0) chk("t3_in_frame_gap", log_cyc[i] - log_cyc[i - 1], 1);
            end
        end
        idle(2);

        // Downstream stall across two frames
        clear_log();
        bus.out_ready = 1'b0;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < N; k++) send($urandom_range(0, 65535) - 32768,
                                             $urandom_range(0, 65535) - 32768, k == N - 1);
        end
        idle(1);
        chk("t4_in_ready_blocked", bus.in_ready, 0);
        chk("t4_out_valid_held", bus.out_valid, 1);
        idle(20);
        chk("t4_nothing_out", log_re.size(), 0);
        bus.out_ready = 1'b1;
        wait_drain(200);
        chk("t4_count", log_re.size(), 2 * N);
        idle(2);

        // Random gaps and random back-pressure over ten frames
        clear_log();
        rand_rdy = 1'b1;
        for (int f = 0; f < 10; f++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
                send($urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768, k == N - 1);
            end
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        wait_drain(500);
        chk("t5_count", log_re.size(), 10 * N);
        chk("t5_err_sync", bus.err_sync, 0);
        idle(2);

        // Misplaced in_last, then reset with buffered data
        clear_log();
        bus.out_ready = 1'b0;
        for (int k = 0; k < N; k++) send(100 + k, -(100 + k), k == 5);
        chk("t6_err_sync", bus.err_sync, 1);
        idle(4);
        chk("t6_err_sticky", bus.err_sync, 1);
        chk("t6_out_valid", bus.out_valid, 1);
        chk("t6_out_re", $signed(bus.out_re), 100);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_out_valid", bus.out_valid, 0);
        chk("t1_out_re", $signed(bus.out_re), 0);
        chk("t1_out_im", $signed(bus.out_im), 0);
        chk("t1_out_idx", bus.out_idx, 0);
        chk("t1_out_last", bus.out_last, 0);
        chk("t1_err_sync", bus.err_sync, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
        idle(1);
        chk("t1_in_ready", bus.in_ready, 1);
        chk("t1_no_stale_output", bus.out_valid, 0);

        // Clean frame after reset
        clear_log();
        bus.out_ready = 1'b1;
        for (int k = 0; k < N; k++) send(3 * k - 7, 5 - k, k == N - 1);
        wait_drain(200);
        chk("t1_post_count", log_re.size(), N);
        if (log_re.size() == N) chk("t1_post_idx1_re", log_re[1], 3 * 4 - 7);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
